systolic_matmul_engine: RTL and testbench

Output-stationary NUM_ROW x NUM_COL systolic MAC array. It computes C = A x B over a runtime inner dimension K and replaces the fixed 8x4 array. Operand skew is applied internally, and a FSM sequences load, flush and drain. Results stream out row-major over a valid/ready channel. It sits between the operand fetch logic and the result writeback/UART path.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_matmul_engine_if.sv | 35 +++
 rtl/systolic_matmul_engine_mac_pe.sv | 48 ++++
 rtl/systolic_matmul_engine.sv | 190 +++++++++++++++++++
 tb/tb_systolic_matmul_engine.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic matmul engine.
package systolic_pkg;
  localparam int DEF_NUM_ROW = 8;
  localparam int DEF_NUM_COL = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_K_W     = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  // Cycles after the last beat until the far-corner PE has accumulated it.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction
endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Operand, control and result channels of the systolic matmul engine.
interface systolic_matmul_engine_if
  import systolic_pkg::*;
#(
  parameter int NUM_ROW = DEF_NUM_ROW,
  parameter int NUM_COL = DEF_NUM_COL,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int K_W     = DEF_K_W
);
  logic                         start;
  logic [K_W-1:0]               k_len;
  logic                         signed_mode;
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_ROW*DATA_W-1:0]    left_data;
  logic [NUM_COL*DATA_W-1:0]    top_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_W-1:0]             out_data;
  logic [$clog2(NUM_ROW)-1:0]   out_row;
  logic [$clog2(NUM_COL)-1:0]   out_col;
  logic                         busy;
  logic                         done;
  logic [15:0]                  cycles_count;

  modport master (
    output start, k_len, signed_mode, in_valid, left_data, top_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, busy, done, cycles_count
  );
  modport slave (
    input  start, k_len, signed_mode, in_valid, left_data, top_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, busy, done, cycles_count
  );
endinterface

// File: rtl/systolic_matmul_engine_mac_pe.sv
// One output-stationary PE: forwards a right / b down, accumulates a*b when both are valid.
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  acc
);
  logic signed [DATA_W:0]     a_ext, b_ext;
  logic signed [2*DATA_W+1:0] prod;

  // One extra bit lets a single signed multiplier cover both modes.
  assign a_ext = {signed_mode & a_in[DATA_W-1], a_in};
  assign b_ext = {signed_mode & b_in[DATA_W-1], b_in};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out     <= '0;
      b_out     <= '0;
      a_vld_out <= 1'b0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      a_vld_out <= a_vld_in;
      b_vld_out <= b_vld_in;
      if (clr)
        acc <= '0;
      else if (a_vld_in && b_vld_in)
        acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/systolic_matmul_engine.sv
// NUM_ROW x NUM_COL output-stationary systolic MAC array with internal operand skew,
// load/flush/drain sequencing and a row-major result stream.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int NUM_ROW = DEF_NUM_ROW,
  parameter int NUM_COL = DEF_NUM_COL,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int K_W     = DEF_K_W
) (
  input logic                     clk,
  input logic                     rst,
  systolic_matmul_engine_if.slave bus
);
  localparam int RW        = $clog2(NUM_ROW);
  localparam int CW        = $clog2(NUM_COL);
  localparam int FLUSH_LEN = flush_len(NUM_ROW, NUM_COL);
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  state_e          state;
  logic [K_W-1:0]  k_q, beat_cnt;
  logic            signed_q;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic            out_valid_q, in_ready_q, busy_q, done_q;
  logic [15:0]     cyc_q;
  logic            beat, clr, last;

  logic [NUM_ROW-1:0][NUM_COL:0][DATA_W-1:0] a_h;
  logic [NUM_ROW-1:0][NUM_COL:0]             av_h;
  logic [NUM_ROW:0][NUM_COL-1:0][DATA_W-1:0] b_v;
  logic [NUM_ROW:0][NUM_COL-1:0]             bv_v;
  logic [NUM_ROW-1:0][NUM_COL-1:0][ACC_W-1:0] acc;

  assign beat = in_ready_q & bus.in_valid;
  assign clr  = (state == IDLE) & bus.start;
  assign last = (row_q == RW'(NUM_ROW-1)) && (col_q == CW'(NUM_COL-1));

  // Row r of A is delayed r cycles so it meets column c of B at PE(r,c) in step.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_rskew
    if (r == 0) begin : g_direct
      assign a_h[r][0]  = bus.left_data[r*DATA_W +: DATA_W];
      assign av_h[r][0] = beat;
    end else begin : g_dly
      logic [r-1:0][DATA_W-1:0] d_pipe;
      logic [r-1:0]             vld_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          d_pipe   <= '0;
          vld_pipe <= '0;
        end else begin
          d_pipe[0]   <= bus.left_data[r*DATA_W +: DATA_W];
          vld_pipe[0] <= beat;
          for (int i = 1; i < r; i++) begin
            d_pipe[i]   <= d_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
          end
        end
      end
      assign a_h[r][0]  = d_pipe[r-1];
      assign av_h[r][0] = vld_pipe[r-1];
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_cskew
    if (c == 0) begin : g_direct
      assign b_v[0][c]  = bus.top_data[c*DATA_W +: DATA_W];
      assign bv_v[0][c] = beat;
    end else begin : g_dly
      logic [c-1:0][DATA_W-1:0] d_pipe;
      logic [c-1:0]             vld_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          d_pipe   <= '0;
          vld_pipe <= '0;
        end else begin
          d_pipe[0]   <= bus.top_data[c*DATA_W +: DATA_W];
          vld_pipe[0] <= beat;
          for (int i = 1; i < c; i++) begin
            d_pipe[i]   <= d_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
          end
        end
      end
      assign b_v[0][c]  = d_pipe[c-1];
      assign bv_v[0][c] = vld_pipe[c-1];
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .signed_mode (signed_q),
        .a_in        (a_h[r][c]),
        .a_vld_in    (av_h[r][c]),
        .b_in        (b_v[r][c]),
        .b_vld_in    (bv_v[r][c]),
        .a_out       (a_h[r][c+1]),
        .a_vld_out   (av_h[r][c+1]),
        .b_out       (b_v[r+1][c]),
        .b_vld_out   (bv_v[r+1][c]),
        .acc         (acc[r][c])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k_q         <= '0;
      beat_cnt    <= '0;
      signed_q    <= 1'b0;
      flush_cnt   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state == LOAD || state == FLUSH) && cyc_q != 16'hFFFF)
        cyc_q <= cyc_q + 16'd1;
      case (state)
        IDLE: if (bus.start) begin
          k_q       <= bus.k_len;
          signed_q  <= bus.signed_mode;
          cyc_q     <= '0;
          beat_cnt  <= '0;
          flush_cnt <= '0;
          busy_q    <= 1'b1;
          if (bus.k_len == '0) begin
            state       <= DRAIN;
            out_valid_q <= 1'b1;
          end else begin
            state      <= LOAD;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: if (bus.in_valid) begin
          if (beat_cnt == k_q - K_W'(1)) begin
            state      <= FLUSH;
            in_ready_q <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + K_W'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(FLUSH_LEN-1)) begin
            state       <= DRAIN;
            out_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: if (bus.out_ready) begin
          if (last) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
          end else if (col_q == CW'(NUM_COL-1)) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = acc[row_q][col_q];
  assign bus.out_row      = row_q;
  assign bus.out_col      = col_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cycles_count = cyc_q;
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Randomized and directed bench for systolic_matmul_engine against a plain matrix-product model.
module tb_systolic_matmul_engine;
  localparam int R    = 8;
  localparam int C    = 8;
  localparam int MAXK = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_matmul_engine_if bus ();
  systolic_matmul_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int a_m [R][MAXK];
  int b_m [MAXK][C];
  int res_d [R*C];
  int res_r [R*C];
  int res_c [R*C];
  int got_n, stall_err, early_done, load_to, gap_sum;
  bit post_ok;
  int n_chk = 0;
  int n_pass = 0;

  // C[r][c] = sum_k A[r][k]*B[k][c], reduced modulo 2^24.
  function automatic int ref_c(input int r, input int c, input int k, input bit sm);
    longint s = 0;
    for (int i = 0; i < k; i++) begin
      longint a = a_m[r][i];
      longint b = b_m[i][c];
      if (sm && a > 127) a -= 256;
      if (sm && b > 127) b -= 256;
      s += a * b;
    end
    return int'(s & 64'hFFFFFF);
  endfunction

  task automatic fill_identity();
    for (int k = 0; k < R; k++) begin
      for (int r = 0; r < R; r++) a_m[r][k] = (r == k) ? 1 : 0;
      for (int c = 0; c < C; c++) b_m[k][c] = k * 8 + c;
    end
  endtask

  task automatic fill_const(input int v, input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < R; r++) a_m[r][i] = v;
      for (int c = 0; c < C; c++) b_m[i][c] = v;
    end
  endtask

  task automatic fill_random(input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < R; r++) a_m[r][i] = int'($urandom_range(0, 255));
      for (int c = 0; c < C; c++) b_m[i][c] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_job(input int k, input bit sm, input int gap, input bit rnd_gap,
                           input bit poke_start);
    load_to = 0;
    gap_sum = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = 16'(k); bus.signed_mode = sm;
    @(negedge clk);
    bus.start = 1'b0; bus.k_len = 16'd5; bus.signed_mode = ~sm;
    for (int i = 0; i < k; i++) begin
      int to;
      int g;
      to = 0;
      while (!bus.in_ready && to < 50) begin @(negedge clk); to++; end
      if (to >= 50) begin load_to++; break; end
      bus.in_valid = 1'b1;
      for (int r = 0; r < R; r++) bus.left_data[r*8 +: 8] = 8'(a_m[r][i]);
      for (int c = 0; c < C; c++) bus.top_data[c*8 +: 8]  = 8'(b_m[i][c]);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.left_data = {$urandom, $urandom};
      bus.top_data  = {$urandom, $urandom};
      if (i < k - 1) begin
        g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
        gap_sum += g;
        repeat (g) @(negedge clk);
      end
    end
    if (poke_start) begin
      bus.start = 1'b1; bus.k_len = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: alternate 1,0, 2: random.
  task automatic collect(input int mode);
    bit stalled;
    int sd, sr, sc, budget;
    got_n = 0; stall_err = 0; early_done = 0; post_ok = 1'b0;
    stalled = 1'b0; budget = 0; sd = 0; sr = 0; sc = 0;
    while (got_n < R*C && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (bus.done) early_done++;
      if (stalled && (!bus.out_valid || int'(bus.out_data) != sd ||
                      int'(bus.out_row) != sr || int'(bus.out_col) != sc))
        stall_err++;
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 1) : 1'($urandom_range(0, 1));
      stalled = bus.out_valid && !bus.out_ready;
      sd = int'(bus.out_data); sr = int'(bus.out_row); sc = int'(bus.out_col);
      if (bus.out_valid && bus.out_ready) begin
        res_d[got_n] = sd; res_r[got_n] = sr; res_c[got_n] = sc;
        got_n++;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    post_ok = bus.done && !bus.out_valid && !bus.busy;
    @(negedge clk);
    post_ok = post_ok && !bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.done} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {bus.in_ready, bus.out_valid, bus.busy, bus.done});
    else n_pass++;
    n_chk++;
    if (bus.out_data !== 24'd0 || bus.out_row !== 3'd0 || bus.out_col !== 3'd0)
      $display("FAIL reset_out got %0d (%0d,%0d) want 0 (0,0)", bus.out_data, bus.out_row, bus.out_col);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd0) $display("FAIL reset_cycles got %0d want 0", bus.cycles_count);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    fill_identity();
    drive_job(8, 1'b0, 0, 1'b0, 1'b0);
    collect(0);
    n_chk++;
    if (got_n !== 64 || load_to !== 0) $display("FAIL t1_count got %0d want 64 (load_to %0d)", got_n, load_to);
    else n_pass++;
    for (int n = 0; n < got_n; n++) begin
      n_chk++;
      if (res_r[n] !== n / 8 || res_c[n] !== n % 8 || res_d[n] !== n)
        $display("FAIL t1_beat%0d got (%0d,%0d)=%0d want (%0d,%0d)=%0d", n, res_r[n], res_c[n], res_d[n], n/8, n%8, n);
      else n_pass++;
    end
    n_chk++;
    if (!post_ok || early_done !== 0) $display("FAIL t1_done post_ok %0d early %0d want 1 0", post_ok, early_done);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd23) $display("FAIL t1_cycles got %0d want 23", bus.cycles_count);
    else n_pass++;
  endtask

  task automatic test_const();
    int bad;
    fill_const(128, 8);
    drive_job(8, 1'b1, 0, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int n = 0; n < got_n; n++) if (res_d[n] !== 131072) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t2_signed got %0d beats, %0d wrong, want 64 beats of 131072", got_n, bad);
    else n_pass++;
    fill_const(255, 8);
    drive_job(8, 1'b0, 0, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int n = 0; n < got_n; n++) if (res_d[n] !== 520200) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t2_unsigned got %0d beats, %0d wrong, want 64 beats of 520200", got_n, bad);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad;
    fill_const(255, 259);
    drive_job(259, 1'b0, 0, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int n = 0; n < got_n; n++) if (res_d[n] !== 64259) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t3_wrap got %0d beats, %0d wrong, want 64 beats of 64259", got_n, bad);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd274) $display("FAIL t3_cycles got %0d want 274", bus.cycles_count);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int bad;
    fill_identity();
    drive_job(8, 1'b0, 3, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int n = 0; n < got_n; n++)
      if (res_r[n] !== n / 8 || res_c[n] !== n % 8 || res_d[n] !== n) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t4_results got %0d beats, %0d wrong, want 64 identity results", got_n, bad);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd44) $display("FAIL t4_cycles got %0d want 44", bus.cycles_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    fill_identity();
    drive_job(8, 1'b0, 0, 1'b0, 1'b1);
    collect(1);
    bad = 0;
    for (int n = 0; n < got_n; n++)
      if (res_r[n] !== n / 8 || res_c[n] !== n % 8 || res_d[n] !== n) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t5_results got %0d beats, %0d wrong, want 64 in order", got_n, bad);
    else n_pass++;
    n_chk++;
    if (stall_err !== 0) $display("FAIL t5_stall_stable got %0d changes want 0", stall_err);
    else n_pass++;
    n_chk++;
    if (!post_ok || early_done !== 0) $display("FAIL t5_done post_ok %0d early %0d want 1 0", post_ok, early_done);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd23) $display("FAIL t5_cycles got %0d want 23", bus.cycles_count);
    else n_pass++;
  endtask

  task automatic test_abort();
    int n, budget, dones, bad;
    fill_const(128, 8);
    drive_job(8, 1'b1, 0, 1'b0, 1'b0);
    n = 0; budget = 0;
    while (budget < 200) begin
      @(negedge clk);
      budget++;
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        if (n == 9) begin rst = 1'b0; break; end
        n++;
      end
    end
    #1;
    n_chk++;
    if (n !== 9 || {bus.busy, bus.out_valid, bus.in_ready} !== 3'b000)
      $display("FAIL t6_abort got beats %0d flags %b want 9 000", n, {bus.busy, bus.out_valid, bus.in_ready});
    else n_pass++;
    dones = 0;
    repeat (3) begin @(negedge clk); if (bus.done) dones++; end
    rst = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done || bus.busy) dones++; end
    n_chk++;
    if (dones !== 0) $display("FAIL t6_no_done got %0d done/busy cycles want 0", dones);
    else n_pass++;
    drive_job(8, 1'b1, 0, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int i = 0; i < got_n; i++) if (res_d[i] !== 131072) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL t6_rerun got %0d beats, %0d wrong, want 64 beats of 131072", got_n, bad);
    else n_pass++;
  endtask

  task automatic test_kzero();
    int bad;
    drive_job(0, 1'b0, 0, 1'b0, 1'b0);
    collect(0);
    bad = 0;
    for (int n = 0; n < got_n; n++) if (res_d[n] !== 0 || res_r[n] !== n / 8 || res_c[n] !== n % 8) bad++;
    n_chk++;
    if (got_n !== 64 || bad !== 0) $display("FAIL k0_results got %0d beats, %0d wrong, want 64 zeros", got_n, bad);
    else n_pass++;
    n_chk++;
    if (bus.cycles_count !== 16'd0 || !post_ok) $display("FAIL k0_cycles got %0d post_ok %0d want 0 1", bus.cycles_count, post_ok);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int k, bad, exp_cyc;
      bit sm;
      k  = int'($urandom_range(1, 24));
      sm = 1'($urandom_range(0, 1));
      fill_random(k);
      drive_job(k, sm, 0, 1'b1, 1'b0);
      collect(2);
      bad = 0;
      for (int n = 0; n < got_n; n++)
        if (res_r[n] !== n / 8 || res_c[n] !== n % 8 || res_d[n] !== ref_c(n / 8, n % 8, k, sm)) bad++;
      n_chk++;
      if (got_n !== 64 || bad !== 0)
        $display("FAIL rnd%0d_results k=%0d sm=%0d got %0d beats, %0d wrong, want 64 matching model", it, k, sm, got_n, bad);
      else n_pass++;
      exp_cyc = k + gap_sum + 15;
      n_chk++;
      if (int'(bus.cycles_count) !== exp_cyc || stall_err !== 0)
        $display("FAIL rnd%0d_cycles got %0d (stall %0d) want %0d (stall 0)", it, bus.cycles_count, stall_err, exp_cyc);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.k_len = '0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b0; bus.left_data = '0; bus.top_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_const();
    test_wrap();
    test_gaps();
    test_backpressure();
    test_abort();
    test_kzero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
